// File: rtl/pipe_rate_ctrl.sv
// MAC-side PIPE rate/PCLK change sequencer: forces TX electrical idle, loads the new
// Rate/PCLKRate and runs the PclkChangeOk/PclkChangeAck/PhyStatus handshake with a timeout.
module pipe_rate_ctrl #(
   parameter int LANESNUMBER    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic                   req_valid,
   input  logic [3:0]             req_rate,
   input  logic [4:0]             req_pclkrate,
   output logic                   req_ready,
   output logic                   done,
   output logic                   error,
   output logic                   tx_hold,
   input  logic [LANESNUMBER-1:0] TxElecIdle_in,
   output logic [LANESNUMBER-1:0] TxElecIdle,
   output logic [3:0]             Rate,
   output logic [4:0]             PCLKRate,
   output logic                   PclkChangeAck,
   input  logic                   PclkChangeOk,
   input  logic [LANESNUMBER-1:0] PhyStatus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EIDLE,
      S_SET,
      S_ACK,
      S_OKLOW
   } state_t;

   state_t                 state_q, state_d;
   logic                   eidle_second_q, eidle_second_d;
   logic [3:0]             tgt_rate_q, tgt_rate_d;
   logic [4:0]             tgt_pclkrate_q, tgt_pclkrate_d;
   logic [3:0]             fb_rate_q, fb_rate_d;
   logic [4:0]             fb_pclkrate_q, fb_pclkrate_d;
   logic [3:0]             rate_q, rate_d;
   logic [4:0]             pclkrate_q, pclkrate_d;
   logic                   ack_q, ack_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic                   hold_q, hold_d;
   logic                   ready_q, ready_d;
   logic [LANESNUMBER-1:0] mask_q, mask_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   timed_out;
   logic [LANESNUMBER-1:0] lanes_seen;

   assign timed_out  = (cnt_q == CW'(TIMEOUT_CYCLES));
   assign lanes_seen = mask_q | PhyStatus;

   always_comb begin
      state_d        = state_q;
      eidle_second_d = eidle_second_q;
      tgt_rate_d     = tgt_rate_q;
      tgt_pclkrate_d = tgt_pclkrate_q;
      fb_rate_d      = fb_rate_q;
      fb_pclkrate_d  = fb_pclkrate_q;
      rate_d         = rate_q;
      pclkrate_d     = pclkrate_q;
      ack_d          = ack_q;
      mask_d         = mask_q;
      cnt_d          = cnt_q;
      done_d         = 1'b0;
      error_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_rate == rate_q && req_pclkrate == pclkrate_q) begin
                  done_d = 1'b1;
               end else begin
                  tgt_rate_d     = req_rate;
                  tgt_pclkrate_d = req_pclkrate;
                  fb_rate_d      = rate_q;
                  fb_pclkrate_d  = pclkrate_q;
                  eidle_second_d = 1'b0;
                  state_d        = S_EIDLE;
               end
            end
         end

         S_EIDLE: begin
            eidle_second_d = 1'b1;
            if (eidle_second_q) begin
               rate_d     = tgt_rate_q;
               pclkrate_d = tgt_pclkrate_q;
               cnt_d      = '0;
               state_d    = S_SET;
            end
         end

         // Handshake states share the timeout, which wins over any handshake progress.
         S_SET, S_ACK, S_OKLOW: begin
            cnt_d = cnt_q + CW'(1);
            if (timed_out) begin
               error_d    = 1'b1;
               ack_d      = 1'b0;
               rate_d     = fb_rate_q;
               pclkrate_d = fb_pclkrate_q;
               state_d    = S_IDLE;
            end else if (state_q == S_SET) begin
               if (PclkChangeOk) begin
                  ack_d   = 1'b1;
                  mask_d  = '0;
                  state_d = S_ACK;
               end
            end else if (state_q == S_ACK) begin
               mask_d = lanes_seen;
               if (&lanes_seen) begin
                  ack_d   = 1'b0;
                  state_d = S_OKLOW;
               end
            end else begin
               if (!PclkChangeOk) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            ack_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      hold_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         eidle_second_q <= 1'b0;
         tgt_rate_q     <= '0;
         tgt_pclkrate_q <= '0;
         fb_rate_q      <= '0;
         fb_pclkrate_q  <= '0;
         rate_q         <= '0;
         pclkrate_q     <= '0;
         ack_q          <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         hold_q         <= 1'b0;
         ready_q        <= 1'b1;
         mask_q         <= '0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         eidle_second_q <= eidle_second_d;
         tgt_rate_q     <= tgt_rate_d;
         tgt_pclkrate_q <= tgt_pclkrate_d;
         fb_rate_q      <= fb_rate_d;
         fb_pclkrate_q  <= fb_pclkrate_d;
         rate_q         <= rate_d;
         pclkrate_q     <= pclkrate_d;
         ack_q          <= ack_d;
         done_q         <= done_d;
         error_q        <= error_d;
         hold_q         <= hold_d;
         ready_q        <= ready_d;
         mask_q         <= mask_d;
         cnt_q          <= cnt_d;
      end
   end

   // The force select is registered; only the final mux onto the PHY lanes is combinational.
   assign TxElecIdle    = hold_q ? {LANESNUMBER{1'b1}} : TxElecIdle_in;
   assign req_ready     = ready_q;
   assign done          = done_q;
   assign error         = error_q;
   assign tx_hold       = hold_q;
   assign Rate          = rate_q;
   assign PCLKRate      = pclkrate_q;
   assign PclkChangeAck = ack_q;

endmodule

// File: tb/tb_pipe_rate_ctrl.sv
// Self-checking bench for pipe_rate_ctrl: a timeline-based reference model checked every
// cycle, plus directed scenarios with hand-computed cycle-exact expectations.
module tb_pipe_rate_ctrl;

   localparam int LANES   = 16;
   localparam int TIMEOUT = 16;

   logic             CLK = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid;
   logic [3:0]       req_rate;
   logic [4:0]       req_pclkrate;
   logic             req_ready;
   logic             done;
   logic             error;
   logic             tx_hold;
   logic [LANES-1:0] TxElecIdle_in;
   logic [LANES-1:0] TxElecIdle;
   logic [3:0]       Rate;
   logic [4:0]       PCLKRate;
   logic             PclkChangeAck;
   logic             PclkChangeOk;
   logic [LANES-1:0] PhyStatus;

   pipe_rate_ctrl #(
      .LANESNUMBER    (LANES),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .CLK           (CLK),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_rate      (req_rate),
      .req_pclkrate  (req_pclkrate),
      .req_ready     (req_ready),
      .done          (done),
      .error         (error),
      .tx_hold       (tx_hold),
      .TxElecIdle_in (TxElecIdle_in),
      .TxElecIdle    (TxElecIdle),
      .Rate          (Rate),
      .PCLKRate      (PCLKRate),
      .PclkChangeAck (PclkChangeAck),
      .PclkChangeOk  (PclkChangeOk),
      .PhyStatus     (PhyStatus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   bit check_en = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] r, input logic [4:0] p,
                                input logic ok, input logic [LANES-1:0] st);
      req_valid    = v;
      req_rate     = r;
      req_pclkrate = p;
      PclkChangeOk = ok;
      PhyStatus    = st;
   endtask

   // Reference model: tracks the age of an accepted change and which handshake milestones
   // the PHY has reached; outputs follow from those facts.
   bit               m_busy = 1'b0;
   int               m_age = 0;
   logic [3:0]       m_rate = '0, m_tgt_rate = '0, m_old_rate = '0;
   logic [4:0]       m_pclk = '0, m_tgt_pclk = '0, m_old_pclk = '0;
   bit               m_ack = 1'b0, m_done = 1'b0, m_err = 1'b0;
   bit               m_ok_seen = 1'b0, m_lanes_done = 1'b0;
   logic [LANES-1:0] m_lanes = '0;

   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_rate = '0;
         m_pclk = '0;
         m_ack  = 1'b0;
         m_done = 1'b0;
         m_err  = 1'b0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (!m_busy) begin
            if (req_valid) begin
               if (req_rate == m_rate && req_pclkrate == m_pclk) begin
                  m_done = 1'b1;
               end else begin
                  m_busy       = 1'b1;
                  m_age        = 0;
                  m_tgt_rate   = req_rate;
                  m_tgt_pclk   = req_pclkrate;
                  m_old_rate   = m_rate;
                  m_old_pclk   = m_pclk;
                  m_ok_seen    = 1'b0;
                  m_lanes_done = 1'b0;
               end
            end
         end else begin
            m_age++;
            if (m_age == 2) begin
               m_rate = m_tgt_rate;
               m_pclk = m_tgt_pclk;
            end else if (m_age >= 3) begin
               if (m_age == 3 + TIMEOUT) begin
                  m_busy = 1'b0;
                  m_err  = 1'b1;
                  m_ack  = 1'b0;
                  m_rate = m_old_rate;
                  m_pclk = m_old_pclk;
               end else if (!m_ok_seen) begin
                  if (PclkChangeOk) begin
                     m_ok_seen = 1'b1;
                     m_ack     = 1'b1;
                     m_lanes   = '0;
                  end
               end else if (!m_lanes_done) begin
                  m_lanes = m_lanes | PhyStatus;
                  if (m_lanes == {LANES{1'b1}}) begin
                     m_lanes_done = 1'b1;
                     m_ack        = 1'b0;
                  end
               end else if (!PclkChangeOk) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end
         end
      end
   end

   always @(posedge CLK) begin
      #1;
      if (check_en) begin
         checkOutput("cyc_req_ready", 32'(req_ready), 32'(!m_busy));
         checkOutput("cyc_tx_hold", 32'(tx_hold), 32'(m_busy));
         checkOutput("cyc_done", 32'(done), 32'(m_done));
         checkOutput("cyc_error", 32'(error), 32'(m_err));
         checkOutput("cyc_Rate", 32'(Rate), 32'(m_rate));
         checkOutput("cyc_PCLKRate", 32'(PCLKRate), 32'(m_pclk));
         checkOutput("cyc_Ack", 32'(PclkChangeAck), 32'(m_ack));
         checkOutput("cyc_TxElecIdle", 32'(TxElecIdle), m_busy ? 32'hFFFF : 32'(TxElecIdle_in));
      end
   end

   logic [3:0]       obs_rate  [0:31];
   logic [4:0]       obs_pclk  [0:31];
   logic             obs_ready [0:31];
   logic [LANES-1:0] obs_eidle [0:31];
   int obs_ack_cnt, obs_ack_first, obs_ack_last, obs_done_cnt, obs_done_at;
   int obs_err_cnt, obs_err_at, obs_force_cnt, obs_hold_cnt;

   // Relative cycle k=0 is the acceptance cycle; outputs of cycle k are recorded at its negedge.
   task automatic run_change(input logic [3:0] r, input logic [4:0] p, input int n_cyc,
                             input int ok_on, input int ok_off,
                             input int sa, input logic [LANES-1:0] ma,
                             input int sb, input logic [LANES-1:0] mb, input int busy_at);
      obs_ack_cnt = 0; obs_ack_first = -1; obs_ack_last = -1;
      obs_done_cnt = 0; obs_done_at = -1; obs_err_cnt = 0; obs_err_at = -1;
      obs_force_cnt = 0; obs_hold_cnt = 0;
      for (int k = 0; k <= n_cyc; k++) begin
         @(negedge CLK);
         if (k > 0) begin
            obs_rate[k]  = Rate;
            obs_pclk[k]  = PCLKRate;
            obs_ready[k] = req_ready;
            obs_eidle[k] = TxElecIdle;
            if (PclkChangeAck) begin
               obs_ack_cnt++;
               if (obs_ack_first < 0) obs_ack_first = k;
               obs_ack_last = k;
            end
            if (done) begin obs_done_cnt++; obs_done_at = k; end
            if (error) begin obs_err_cnt++; obs_err_at = k; end
            if (TxElecIdle === {LANES{1'b1}}) obs_force_cnt++;
            if (tx_hold) obs_hold_cnt++;
         end
         applyStimulus((k == 0) || (k == busy_at),
                       (k == busy_at) ? 4'd5 : r,
                       (k == busy_at) ? 5'd5 : p,
                       (k >= ok_on) && (k < ok_off),
                       ((k == sa) ? ma : '0) | ((k == sb) ? mb : '0));
      end
   endtask

   initial begin
      applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, '0);
      TxElecIdle_in = 16'h1234;
      #1 rst_n = 1'b0;
      check_en = 1'b1;
      repeat (3) @(negedge CLK);
      checkOutput("reset_Rate", 32'(Rate), 32'd0);
      checkOutput("reset_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_TxElecIdle", 32'(TxElecIdle), 32'h1234);
      rst_n = 1'b1;

      $display("[TB] timeout: Rate 0->4, PHY never answers");
      run_change(4'd4, 5'd1, 23, 100, 100, 6, 16'hFFFF, -1, '0, -1);
      checkOutput("to_rate_old", 32'(obs_rate[2]), 32'd0);
      checkOutput("to_rate_new", 32'(obs_rate[3]), 32'd4);
      checkOutput("to_rate_last", 32'(obs_rate[19]), 32'd4);
      checkOutput("to_err_at", 32'(obs_err_at), 32'd20);
      checkOutput("to_err_cnt", 32'(obs_err_cnt), 32'd1);
      checkOutput("to_done_cnt", 32'(obs_done_cnt), 32'd0);
      checkOutput("to_ack_cnt", 32'(obs_ack_cnt), 32'd0);
      checkOutput("to_rate_revert", 32'(obs_rate[20]), 32'd0);
      checkOutput("to_pclk_revert", 32'(obs_pclk[20]), 32'd0);
      checkOutput("to_ready_before", 32'(obs_ready[19]), 32'd0);
      checkOutput("to_ready_after", 32'(obs_ready[20]), 32'd1);
      checkOutput("to_force_cnt", 32'(obs_force_cnt), 32'd19);

      $display("[TB] Gen1->Gen3: Rate 0->2");
      TxElecIdle_in = 16'h00A5;
      run_change(4'd2, 5'd2, 18, 8, 14, 12, 16'hFFFF, 5, 16'hFFFF, -1);
      checkOutput("g3_rate_old", 32'(obs_rate[2]), 32'd0);
      checkOutput("g3_rate_new", 32'(obs_rate[3]), 32'd2);
      checkOutput("g3_pclk_new", 32'(obs_pclk[3]), 32'd2);
      checkOutput("g3_ack_first", 32'(obs_ack_first), 32'd9);
      checkOutput("g3_ack_cnt", 32'(obs_ack_cnt), 32'd4);
      checkOutput("g3_done_at", 32'(obs_done_at), 32'd15);
      checkOutput("g3_done_cnt", 32'(obs_done_cnt), 32'd1);
      checkOutput("g3_err_cnt", 32'(obs_err_cnt), 32'd0);
      checkOutput("g3_force_cnt", 32'(obs_force_cnt), 32'd14);
      checkOutput("g3_hold_cnt", 32'(obs_hold_cnt), 32'd14);
      checkOutput("g3_eidle_release", 32'(obs_eidle[15]), 32'h00A5);
      checkOutput("g3_ready_after", 32'(obs_ready[15]), 32'd1);

      $display("[TB] staggered PhyStatus with busy request during Ack");
      run_change(4'd3, 5'd3, 15, 3, 11, 5, 16'h00FF, 9, 16'hFF00, 6);
      checkOutput("st_ack_first", 32'(obs_ack_first), 32'd4);
      checkOutput("st_ack_last", 32'(obs_ack_last), 32'd9);
      checkOutput("st_ack_cnt", 32'(obs_ack_cnt), 32'd6);
      checkOutput("st_done_at", 32'(obs_done_at), 32'd12);
      checkOutput("st_done_cnt", 32'(obs_done_cnt), 32'd1);
      checkOutput("st_rate_final", 32'(obs_rate[15]), 32'd3);
      checkOutput("st_pclk_final", 32'(obs_pclk[15]), 32'd3);

      $display("[TB] same-rate request");
      run_change(4'd3, 5'd3, 3, 100, 100, -1, '0, -1, '0, -1);
      checkOutput("sr_done_at", 32'(obs_done_at), 32'd1);
      checkOutput("sr_done_cnt", 32'(obs_done_cnt), 32'd1);
      checkOutput("sr_hold_cnt", 32'(obs_hold_cnt), 32'd0);
      checkOutput("sr_ready", 32'(obs_ready[1]), 32'd1);
      checkOutput("sr_eidle", 32'(obs_eidle[1]), 32'h00A5);

      $display("[TB] reset during Ack");
      run_change(4'd1, 5'd1, 5, 3, 100, -1, '0, -1, '0, -1);
      checkOutput("rst_pre_ack", 32'(PclkChangeAck), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_ack", 32'(PclkChangeAck), 32'd0);
      checkOutput("rst_rate", 32'(Rate), 32'd0);
      checkOutput("rst_pclk", 32'(PCLKRate), 32'd0);
      checkOutput("rst_hold", 32'(tx_hold), 32'd0);
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_eidle", 32'(TxElecIdle), 32'h00A5);
      applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, '0);
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;

      $display("[TB] minimum-latency change after reset");
      run_change(4'd2, 5'd2, 8, 3, 5, 4, 16'hFFFF, -1, '0, -1);
      checkOutput("min_rate", 32'(obs_rate[3]), 32'd2);
      checkOutput("min_ack_first", 32'(obs_ack_first), 32'd4);
      checkOutput("min_ack_cnt", 32'(obs_ack_cnt), 32'd1);
      checkOutput("min_done_at", 32'(obs_done_at), 32'd6);
      checkOutput("min_err_cnt", 32'(obs_err_cnt), 32'd0);

      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
